// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, channel indices and default timing for the button conditioner
package btn_pkg;

    localparam logic [1:0] ST_LOW    = 2'b00;
    localparam logic [1:0] ST_CHK_HI = 2'b01;
    localparam logic [1:0] ST_HIGH   = 2'b10;
    localparam logic [1:0] ST_CHK_LO = 2'b11;

    localparam int BTN_P1   = 0;
    localparam int BTN_P2   = 1;
    localparam int BTN_KICK = 2;

    localparam int DB_CYCLES_DEF   = 500000;
    localparam int HOLD_CYCLES_DEF = 25000000;
    localparam int RPT_CYCLES_DEF  = 10000000;

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button channel: 2-flop synchroniser, debounce FSM, registered level/press/release
// Optional auto-repeat of btn_press while held is built when BTN_AUTOREPEAT_EN is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = 20,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2((HOLD_CYCLES > RPT_CYCLES ? HOLD_CYCLES : RPT_CYCLES) + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(RPT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rpt_q, rpt_d;
`else
    // Repeat timing is meaningless without the hold counter; referenced only to keep the interface uniform.
    logic unused_cfg;
    assign unused_cfg = (HOLD_CYCLES > 0) ^ (RPT_CYCLES > 0);
`endif

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CHK_HI: begin
                if (!sync2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

`ifdef BTN_AUTOREPEAT_EN
        // Only a channel staying in HIGH repeats; any 0 sample drops to CHK_LO and clears the hold timer.
        hold_d = '0;
        rpt_d  = 1'b0;
        if (state_q == ST_HIGH && sync2_q) begin
            if (hold_q == (rpt_q ? RPT_LAST : HOLD_LAST)) begin
                press_d = 1'b1;
                hold_d  = '0;
                rpt_d   = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
                rpt_d  = rpt_q;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rpt_q  <= rpt_d;
        end
    end
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent debounce channels (p1, p2, kick) feeding the game logic
// Auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN       = BTN_KICK + 1,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = 20,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W),
            .HOLD_CYCLES(HOLD_CYCLES),
            .RPT_CYCLES (RPT_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule
